// File: rtl/mux4_tdm_sequencer.sv
// Round-robin select sequencer for a 4:1 mux cell.
// Dwells on each enabled input, then captures Z into Q.
module mux4_tdm_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               CLK,
    input  logic               RN,
    input  logic               EN,
    input  logic               ONESHOT,
    input  logic [3:0]         CH_EN,
    input  logic [DWELL_W-1:0] DWELL,
    input  logic               Z_IN,
    output logic               S0,
    output logic               S1,
    output logic [3:0]         Q,
    output logic               VLD,
    output logic [1:0]         CH_O,
    output logic               DONE,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         start_q, start_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         q_q, q_d;
    logic [1:0]         cho_q, cho_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;
    logic [1:0]         nxt_sel;
    logic [1:0]         low_sel;

    // First enabled channel after c, wrapping; c itself only if alone.
    function automatic logic [1:0] nxt(input logic [1:0] c,
                                       input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] idx;
        r = c;
        for (int k = 4; k >= 1; k--) begin
            idx = c + 2'(k);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    // Lowest-numbered enabled channel.
    function automatic logic [1:0] low(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) r = 2'(k);
        end
        return r;
    endfunction

    assign nxt_sel = nxt(sel_q, CH_EN);
    assign low_sel = low(CH_EN);

    // Next-state and capture decisions.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        cho_d   = cho_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (EN && (|CH_EN)) begin
                    sel_d   = low_sel;
                    start_d = low_sel;
                    cnt_d   = DWELL;
                    state_d = SETTLE;
                end
            end
            SETTLE, SAMPLE: begin
                if (!EN) begin
                    state_d = IDLE;
                end else if (!CH_EN[sel_q]) begin
                    // Selected input dropped: skip it, no capture.
                    if (|CH_EN) begin
                        sel_d   = nxt_sel;
                        cnt_d   = DWELL;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == SETTLE) begin
                    if (cnt_q == '0) state_d = SAMPLE;
                    else             cnt_d   = cnt_q - ONE;
                end else begin
                    q_d[sel_q] = Z_IN;
                    vld_d      = 1'b1;
                    cho_d      = sel_q;
                    if (ONESHOT && (nxt_sel == start_q)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sel_d   = nxt_sel;
                        cnt_d   = DWELL;
                        state_d = SETTLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            start_q <= 2'd0;
            cnt_q   <= '0;
            q_q     <= 4'd0;
            cho_q   <= 2'd0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            cho_q   <= cho_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign S0   = sel_q[0];
    assign S1   = sel_q[1];
    assign Q    = q_q;
    assign VLD  = vld_q;
    assign CH_O = cho_q;
    assign DONE = done_q;
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_mux4_tdm_sequencer.sv
// Directed bench for mux4_tdm_sequencer.
// Vector table for round-robin cases, hand sequences for corners.
module tb_mux4_tdm_sequencer;

    logic       CLK = 1'b0;
    logic       RN = 1'b0;
    logic       EN = 1'b0;
    logic       ONESHOT = 1'b0;
    logic [3:0] CH_EN = 4'd0;
    logic [3:0] DWELL = 4'd0;
    logic       Z_IN = 1'b0;
    logic       S0, S1, VLD, DONE, BUSY;
    logic [3:0] Q;
    logic [1:0] CH_O;

    int ncmp = 0;
    int nfail = 0;

    mux4_tdm_sequencer #(.DWELL_W(4)) dut (
        .CLK(CLK), .RN(RN), .EN(EN), .ONESHOT(ONESHOT),
        .CH_EN(CH_EN), .DWELL(DWELL), .Z_IN(Z_IN),
        .S0(S0), .S1(S1), .Q(Q), .VLD(VLD), .CH_O(CH_O),
        .DONE(DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       en;
        logic       os;
        logic [3:0] chen;
        logic [3:0] dwell;
        logic       z;
        logic [1:0] sel;
        logic       vld;
        logic [1:0] cho;
        logic       done;
        logic       busy;
        logic [3:0] q;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input string tag);
        EN = 1'b0;
        ONESHOT = 1'b0;
        CH_EN = 4'd0;
        DWELL = 4'd0;
        Z_IN = 1'b0;
        RN = 1'b0;
        #2;
        chk({tag, " rst sel"}, {S1, S0}, 0);
        chk({tag, " rst q"}, Q, 0);
        chk({tag, " rst busy"}, BUSY, 0);
        chk({tag, " rst vld"}, VLD, 0);
        RN = 1'b1;
    endtask

    task automatic chk_all(input string tag, input int sel, input int vld,
                           input int cho, input int done, input int busy,
                           input int q);
        chk({tag, " sel"}, {S1, S0}, sel);
        chk({tag, " vld"}, VLD, vld);
        chk({tag, " cho"}, CH_O, cho);
        chk({tag, " done"}, DONE, done);
        chk({tag, " busy"}, BUSY, busy);
        chk({tag, " q"}, Q, q);
    endtask

    initial begin
        // Four channels, dwell 0, continuous, Z=1.
        tbl[0]  = '{1, 1, 0, 4'b1111, 4'd0, 1, 2'd0, 0, 2'd0, 0, 1, 4'b0000};
        tbl[1]  = '{0, 1, 0, 4'b1111, 4'd0, 1, 2'd0, 0, 2'd0, 0, 1, 4'b0000};
        tbl[2]  = '{0, 1, 0, 4'b1111, 4'd0, 1, 2'd1, 1, 2'd0, 0, 1, 4'b0001};
        tbl[3]  = '{0, 1, 0, 4'b1111, 4'd0, 1, 2'd1, 0, 2'd0, 0, 1, 4'b0001};
        tbl[4]  = '{0, 1, 0, 4'b1111, 4'd0, 1, 2'd2, 1, 2'd1, 0, 1, 4'b0011};
        tbl[5]  = '{0, 1, 0, 4'b1111, 4'd0, 1, 2'd2, 0, 2'd1, 0, 1, 4'b0011};
        tbl[6]  = '{0, 1, 0, 4'b1111, 4'd0, 1, 2'd3, 1, 2'd2, 0, 1, 4'b0111};
        tbl[7]  = '{0, 1, 0, 4'b1111, 4'd0, 1, 2'd3, 0, 2'd2, 0, 1, 4'b0111};
        tbl[8]  = '{0, 1, 0, 4'b1111, 4'd0, 1, 2'd0, 1, 2'd3, 0, 1, 4'b1111};
        // Channels 1 and 3, dwell 3; Z=0 on ch1, Z=1 on ch3.
        tbl[9]  = '{1, 1, 0, 4'b1010, 4'd3, 0, 2'd1, 0, 2'd0, 0, 1, 4'b0000};
        tbl[10] = '{0, 1, 0, 4'b1010, 4'd3, 0, 2'd1, 0, 2'd0, 0, 1, 4'b0000};
        tbl[11] = '{0, 1, 0, 4'b1010, 4'd3, 0, 2'd1, 0, 2'd0, 0, 1, 4'b0000};
        tbl[12] = '{0, 1, 0, 4'b1010, 4'd3, 0, 2'd1, 0, 2'd0, 0, 1, 4'b0000};
        tbl[13] = '{0, 1, 0, 4'b1010, 4'd3, 0, 2'd1, 0, 2'd0, 0, 1, 4'b0000};
        tbl[14] = '{0, 1, 0, 4'b1010, 4'd3, 0, 2'd3, 1, 2'd1, 0, 1, 4'b0000};
        tbl[15] = '{0, 1, 0, 4'b1010, 4'd3, 1, 2'd3, 0, 2'd1, 0, 1, 4'b0000};
        tbl[16] = '{0, 1, 0, 4'b1010, 4'd3, 1, 2'd3, 0, 2'd1, 0, 1, 4'b0000};
        tbl[17] = '{0, 1, 0, 4'b1010, 4'd3, 1, 2'd3, 0, 2'd1, 0, 1, 4'b0000};
        tbl[18] = '{0, 1, 0, 4'b1010, 4'd3, 1, 2'd3, 0, 2'd1, 0, 1, 4'b0000};
        tbl[19] = '{0, 1, 0, 4'b1010, 4'd3, 1, 2'd1, 1, 2'd3, 0, 1, 4'b1000};

        RN = 1'b0;
        step(1);
        chk_all("por", 0, 0, 0, 0, 0, 0);
        RN = 1'b1;

        for (int i = 0; i < 20; i++) begin
            if (tbl[i].rst) do_reset($sformatf("v%0d", i));
            EN      = tbl[i].en;
            ONESHOT = tbl[i].os;
            CH_EN   = tbl[i].chen;
            DWELL   = tbl[i].dwell;
            Z_IN    = tbl[i].z;
            step(1);
            chk_all($sformatf("v%0d", i), tbl[i].sel, tbl[i].vld,
                    tbl[i].cho, tbl[i].done, tbl[i].busy, tbl[i].q);
        end

        // Oneshot round over channels 1,2 with dwell 1.
        do_reset("os");
        ONESHOT = 1'b1;
        CH_EN = 4'b0110;
        DWELL = 4'd1;
        Z_IN = 1'b1;
        EN = 1'b1;
        step(1);
        chk("os first sel", {S1, S0}, 1);
        step(3);
        chk_all("os vld1", 2, 1, 1, 0, 1, 4'b0010);
        step(3);
        chk_all("os done", 2, 1, 2, 1, 0, 4'b0110);
        EN = 1'b0;
        step(1);
        chk_all("os idle", 2, 0, 2, 0, 0, 4'b0110);
        EN = 1'b1;
        step(1);
        chk("os restart sel", {S1, S0}, 1);
        chk("os restart busy", BUSY, 1);

        // Channel 2 dropped mid-dwell.
        do_reset("drop");
        CH_EN = 4'b1111;
        DWELL = 4'd3;
        Z_IN = 1'b1;
        EN = 1'b1;
        step(11);
        chk_all("drop on2", 2, 1, 1, 0, 1, 4'b0011);
        step(1);
        CH_EN = 4'b1011;
        step(1);
        chk_all("drop skip", 3, 0, 1, 0, 1, 4'b0011);
        step(5);
        chk_all("drop cap3", 0, 1, 3, 0, 1, 4'b1011);

        // Async reset mid-dwell on channel 3.
        do_reset("ar");
        CH_EN = 4'b1111;
        DWELL = 4'd0;
        Z_IN = 1'b1;
        EN = 1'b1;
        step(9);
        chk("ar q full", Q, 4'b1111);
        DWELL = 4'd3;
        step(13);
        chk("ar on3", {S1, S0}, 3);
        chk("ar busy", BUSY, 1);
        RN = 1'b0;
        #1;
        chk_all("ar clear", 0, 0, 0, 0, 0, 0);
        #1;
        RN = 1'b1;
        CH_EN = 4'b1100;
        step(1);
        chk("ar restart sel", {S1, S0}, 2);
        chk("ar restart busy", BUSY, 1);

        // Single channel, dwell 2, continuous.
        do_reset("one");
        CH_EN = 4'b0001;
        DWELL = 4'd2;
        EN = 1'b1;
        Z_IN = 1'b0;
        step(4);
        chk("one no vld yet", VLD, 0);
        Z_IN = 1'b1;
        step(1);
        chk_all("one cap1", 0, 1, 0, 0, 1, 4'b0001);
        Z_IN = 1'b0;
        step(1);
        chk("one vld low", VLD, 0);
        step(2);
        chk("one vld low2", VLD, 0);
        step(1);
        chk_all("one cap0", 0, 1, 0, 0, 1, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mux4_tdm_sequencer.md
Name: mux4_tdm_sequencer

Overview:
Time-division sequencer that drives the S1/S0 select pins of a 4:1 mux cell and captures the mux output Z for each enabled channel. It walks the enabled inputs I0..I3 round-robin and holds each select for a programmable settling dwell. It then samples Z into a per-channel holding register and flags the capture. It sits directly upstream of the mux select inputs and directly downstream of its Z output.

Parameters:
DWELL_W, 4, width of the DWELL settling-count input; maximum dwell is 2^DWELL_W-1 extra cycles.

Ports:
CLK  input  1  clock, rising-edge active
RN  input  1  asynchronous active-low reset
EN  input  1  sequencer run enable
ONESHOT  input  1  1 = one round over enabled channels then stop; 0 = continuous
CH_EN  input  4  per-channel enable, bit n = mux input In
DWELL  input  DWELL_W  extra settling cycles after a select change
Z_IN  input  1  mux Z output fed back
S0  output  1  mux select LSB (registered)
S1  output  1  mux select MSB (registered)
Q  output  4  captured Z value per channel, bit n = channel n
VLD  output  1  one-cycle pulse: Q[CH_O] updated at the preceding edge
CH_O  output  2  channel index of the latest capture
DONE  output  1  one-cycle pulse at end of a ONESHOT round
BUSY  output  1  high in SETTLE or SAMPLE

Behaviour:
- Reset, asynchronous on RN low:
  - {S1,S0}=00, Q=0000, VLD=0, CH_O=00, DONE=0, BUSY=0.
  - State=IDLE, dwell counter=0, round-start register=0.
  - RN mid-dwell aborts immediately; no capture occurs.
- States: IDLE, SETTLE, SAMPLE. BUSY = (state != IDLE).
- Channel selection:
  - next(c) = first enabled channel scanning c+1, c+2, c+3, c+4, all mod 4. A wrap from 3 to 0 is normal.
  - The current channel is selected again only if it is the sole enabled channel.
- IDLE -> SETTLE when EN=1 and CH_EN!=0. At that edge:
  - {S1,S0} <= lowest enabled channel.
  - cnt <= DWELL.
  - The round start is recorded as that channel.
- SETTLE:
  - Each cycle: if cnt==0, go to SAMPLE; else cnt--.
  - SETTLE therefore lasts DWELL+1 cycles.
- SAMPLE lasts one cycle. At its closing edge:
  - Q[sel] <= Z_IN; VLD <= 1; CH_O <= sel.
  - If ONESHOT=1 and next(sel) equals the round start (all enabled channels sampled once): go to IDLE, DONE <= 1, select held.
  - Otherwise: {S1,S0} <= next(sel), cnt <= DWELL, go to SETTLE.
- Period per channel is DWELL+2 cycles. VLD is high in the first SETTLE cycle of the following channel.
- CH_EN is sampled every cycle:
  - If the selected channel is disabled during SETTLE or SAMPLE, abort with no capture and no VLD.
  - If any channel is still enabled, move to next(sel) with cnt <= DWELL; otherwise go to IDLE.
- EN=0 in SETTLE or SAMPLE: go to IDLE at the next edge, no capture, select held.
- DWELL is sampled only when cnt is loaded. Changes mid-dwell take effect on the next channel.
- ONESHOT is sampled only at the SAMPLE closing edge. In IDLE with ONESHOT=1 and EN held high, a new round starts the next cycle. DONE and VLD may be high in the same cycle.
- Q bits of disabled channels hold their last value.
- VLD and DONE are never high for more than one consecutive cycle per event.

Test Plan:
1. Reset, then CH_EN=1111, DWELL=0, EN=1, ONESHOT=0, Z_IN=1 -> select sequence 00,01,10,11,00 with each select held 2 cycles; VLD every 2nd cycle; CH_O 0,1,2,3; Q=1111.
2. CH_EN=1010, DWELL=3, Z_IN=0 on channel 1 and 1 on channel 3 -> select alternates 01,11, each held 5 cycles; Q=1000; channels 0 and 2 never selected.
3. ONESHOT=1, CH_EN=0110, DWELL=1 -> selects 01 then 10; two VLD pulses; DONE pulses with the second VLD; back in IDLE with BUSY=0 and select held 10.
4. CH_EN bit 2 cleared at cnt=2 while select=10, other channels enabled -> no VLD for channel 2; the next edge selects 11; Q[2] unchanged.
5. RN pulsed low mid-SETTLE on channel 3 with Q=1111 -> all outputs clear asynchronously (Q=0000, select 00); after RN high and EN=1, restart at the lowest enabled channel.
6. CH_EN=0001, DWELL=2, continuous mode -> select stays 00; VLD every 4 cycles with CH_O=00; Q[0] tracks Z_IN.
